// File: rtl/ysyx_23060077_axi_demux_n.sv
// AXI4 1-master to NUM_SLV-slave address demultiplexer.
// The slave is decoded from base/mask windows and latched once per transaction.
// Read and write paths are independent FSMs, and each allows one outstanding transaction.
// Addresses that hit no window go to an internal error slave that answers DECERR (2'b11).
// Handshake rule: a transfer happens in a cycle where valid and ready are both high.
// A valid, once raised, stays up until the transfer completes.
module ysyx_23060077_axi_demux_n #(
  parameter int NUM_SLV = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0,
  localparam int STRB_W = DATA_W / 8,
  localparam int SEL_W  = $clog2(NUM_SLV + 1)
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  input  logic                        m_aw_valid_i,
  input  logic [ADDR_W-1:0]           m_aw_addr_i,
  input  logic [ID_W-1:0]             m_aw_id_i,
  input  logic [7:0]                  m_aw_len_i,
  input  logic [2:0]                  m_aw_size_i,
  input  logic [1:0]                  m_aw_burst_i,
  output logic                        m_aw_ready_o,
  input  logic                        m_w_valid_i,
  input  logic [DATA_W-1:0]           m_w_data_i,
  input  logic [STRB_W-1:0]           m_w_strb_i,
  input  logic                        m_w_last_i,
  output logic                        m_w_ready_o,
  input  logic                        m_b_ready_i,
  output logic                        m_b_valid_o,
  output logic [1:0]                  m_b_resp_o,
  output logic [ID_W-1:0]             m_b_id_o,
  input  logic                        m_ar_valid_i,
  input  logic [ADDR_W-1:0]           m_ar_addr_i,
  input  logic [ID_W-1:0]             m_ar_id_i,
  input  logic [7:0]                  m_ar_len_i,
  input  logic [2:0]                  m_ar_size_i,
  input  logic [1:0]                  m_ar_burst_i,
  output logic                        m_ar_ready_o,
  input  logic                        m_r_ready_i,
  output logic                        m_r_valid_o,
  output logic [1:0]                  m_r_resp_o,
  output logic [DATA_W-1:0]           m_r_data_o,
  output logic                        m_r_last_o,
  output logic [ID_W-1:0]             m_r_id_o,
  output logic [NUM_SLV-1:0]          s_aw_valid_o,
  output logic [NUM_SLV*ADDR_W-1:0]   s_aw_addr_o,
  output logic [NUM_SLV*ID_W-1:0]     s_aw_id_o,
  output logic [NUM_SLV*8-1:0]        s_aw_len_o,
  output logic [NUM_SLV*3-1:0]        s_aw_size_o,
  output logic [NUM_SLV*2-1:0]        s_aw_burst_o,
  input  logic [NUM_SLV-1:0]          s_aw_ready_i,
  output logic [NUM_SLV-1:0]          s_w_valid_o,
  output logic [NUM_SLV*DATA_W-1:0]   s_w_data_o,
  output logic [NUM_SLV*STRB_W-1:0]   s_w_strb_o,
  output logic [NUM_SLV-1:0]          s_w_last_o,
  input  logic [NUM_SLV-1:0]          s_w_ready_i,
  output logic [NUM_SLV-1:0]          s_b_ready_o,
  input  logic [NUM_SLV-1:0]          s_b_valid_i,
  input  logic [NUM_SLV*2-1:0]        s_b_resp_i,
  input  logic [NUM_SLV*ID_W-1:0]     s_b_id_i,
  output logic [NUM_SLV-1:0]          s_ar_valid_o,
  output logic [NUM_SLV*ADDR_W-1:0]   s_ar_addr_o,
  output logic [NUM_SLV*ID_W-1:0]     s_ar_id_o,
  output logic [NUM_SLV*8-1:0]        s_ar_len_o,
  output logic [NUM_SLV*3-1:0]        s_ar_size_o,
  output logic [NUM_SLV*2-1:0]        s_ar_burst_o,
  input  logic [NUM_SLV-1:0]          s_ar_ready_i,
  output logic [NUM_SLV-1:0]          s_r_ready_o,
  input  logic [NUM_SLV-1:0]          s_r_valid_i,
  input  logic [NUM_SLV*2-1:0]        s_r_resp_i,
  input  logic [NUM_SLV*DATA_W-1:0]   s_r_data_i,
  input  logic [NUM_SLV-1:0]          s_r_last_i,
  input  logic [NUM_SLV*ID_W-1:0]     s_r_id_i,
  output logic [1:0]                  dbg_w_state_o,
  output logic [1:0]                  dbg_r_state_o
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

  localparam logic [SEL_W-1:0] ERR_SEL = SEL_W'(NUM_SLV);

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic [SEL_W-1:0] wsel_q, wsel_d, rsel_q, rsel_d;
  logic [ID_W-1:0]  aw_id_q, aw_id_d, ar_id_q, ar_id_d;
  logic [7:0]       ar_len_q, ar_len_d, cnt_q, cnt_d;
  logic             w_err, r_err;

  // Window decode. The loop runs from the top index down, so the lowest matching index wins.
  function automatic logic [SEL_W-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [SEL_W-1:0] sel;
    sel = ERR_SEL;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) sel = SEL_W'(i);
    end
    return sel;
  endfunction

  assign w_err = (wsel_q == ERR_SEL);
  assign r_err = (rsel_q == ERR_SEL);
  assign dbg_w_state_o = w_state_q;
  assign dbg_r_state_o = r_state_q;

  // State and latched route registers. Reset aborts any transaction in flight.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      wsel_q    <= '0;
      rsel_q    <= '0;
      aw_id_q   <= '0;
      ar_id_q   <= '0;
      ar_len_q  <= '0;
      cnt_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wsel_q    <= wsel_d;
      rsel_q    <= rsel_d;
      aw_id_q   <= aw_id_d;
      ar_id_q   <= ar_id_d;
      ar_len_q  <= ar_len_d;
      cnt_q     <= cnt_d;
    end
  end

  // Write FSM next state. The route is latched in IDLE, which adds one cycle of latency.
  always_comb begin
    w_state_d = w_state_q;
    wsel_d    = wsel_q;
    aw_id_d   = aw_id_q;
    case (w_state_q)
      W_IDLE: if (m_aw_valid_i) begin
        wsel_d    = decode(m_aw_addr_i);
        aw_id_d   = m_aw_id_i;
        w_state_d = W_ADDR;
      end
      W_ADDR: if (m_aw_valid_i && m_aw_ready_o) w_state_d = W_DATA;
      W_DATA: if (m_w_valid_i && m_w_ready_o && m_w_last_i) w_state_d = W_RESP;
      W_RESP: if (m_b_valid_o && m_b_ready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM next state. The beat counter drives the error slave's last flag.
  always_comb begin
    r_state_d = r_state_q;
    rsel_d    = rsel_q;
    ar_id_d   = ar_id_q;
    ar_len_d  = ar_len_q;
    cnt_d     = cnt_q;
    case (r_state_q)
      R_IDLE: if (m_ar_valid_i) begin
        rsel_d    = decode(m_ar_addr_i);
        ar_id_d   = m_ar_id_i;
        ar_len_d  = m_ar_len_i;
        r_state_d = R_ADDR;
      end
      R_ADDR: if (m_ar_valid_i && m_ar_ready_o) begin
        cnt_d     = '0;
        r_state_d = R_DATA;
      end
      R_DATA: if (m_r_valid_o && m_r_ready_i) begin
        cnt_d = cnt_q + 8'd1;
        if (m_r_last_o) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write channel routing. Only the latched slave, or the error slave, sees traffic.
  always_comb begin
    m_aw_ready_o = 1'b0;
    m_w_ready_o  = 1'b0;
    m_b_valid_o  = 1'b0;
    m_b_resp_o   = 2'b00;
    m_b_id_o     = '0;
    s_aw_valid_o = '0;
    s_aw_addr_o  = '0;
    s_aw_id_o    = '0;
    s_aw_len_o   = '0;
    s_aw_size_o  = '0;
    s_aw_burst_o = '0;
    s_w_valid_o  = '0;
    s_w_data_o   = '0;
    s_w_strb_o   = '0;
    s_w_last_o   = '0;
    s_b_ready_o  = '0;
    if (w_err) begin
      m_aw_ready_o = (w_state_q == W_ADDR);
      m_w_ready_o  = (w_state_q == W_DATA);
      if (w_state_q == W_RESP) begin
        m_b_valid_o = 1'b1;
        m_b_resp_o  = 2'b11;
        m_b_id_o    = aw_id_q;
      end
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!w_err && wsel_q == SEL_W'(i)) begin
        if (w_state_q == W_ADDR) begin
          s_aw_valid_o[i]                 = m_aw_valid_i;
          s_aw_addr_o[i*ADDR_W +: ADDR_W] = m_aw_addr_i;
          s_aw_id_o[i*ID_W +: ID_W]       = m_aw_id_i;
          s_aw_len_o[i*8 +: 8]            = m_aw_len_i;
          s_aw_size_o[i*3 +: 3]           = m_aw_size_i;
          s_aw_burst_o[i*2 +: 2]          = m_aw_burst_i;
          m_aw_ready_o                    = s_aw_ready_i[i];
        end
        if (w_state_q == W_DATA) begin
          s_w_valid_o[i]                 = m_w_valid_i;
          s_w_data_o[i*DATA_W +: DATA_W] = m_w_data_i;
          s_w_strb_o[i*STRB_W +: STRB_W] = m_w_strb_i;
          s_w_last_o[i]                  = m_w_last_i;
          m_w_ready_o                    = s_w_ready_i[i];
        end
        if (w_state_q == W_RESP) begin
          s_b_ready_o[i] = m_b_ready_i;
          m_b_valid_o    = s_b_valid_i[i];
          m_b_resp_o     = s_b_resp_i[i*2 +: 2];
          m_b_id_o       = s_b_id_i[i*ID_W +: ID_W];
        end
      end
    end
  end

  // Read channel routing. The error slave returns ar_len+1 zero beats with DECERR.
  always_comb begin
    m_ar_ready_o = 1'b0;
    m_r_valid_o  = 1'b0;
    m_r_resp_o   = 2'b00;
    m_r_data_o   = '0;
    m_r_last_o   = 1'b0;
    m_r_id_o     = '0;
    s_ar_valid_o = '0;
    s_ar_addr_o  = '0;
    s_ar_id_o    = '0;
    s_ar_len_o   = '0;
    s_ar_size_o  = '0;
    s_ar_burst_o = '0;
    s_r_ready_o  = '0;
    if (r_err) begin
      m_ar_ready_o = (r_state_q == R_ADDR);
      if (r_state_q == R_DATA) begin
        m_r_valid_o = 1'b1;
        m_r_resp_o  = 2'b11;
        m_r_last_o  = (cnt_q == ar_len_q);
        m_r_id_o    = ar_id_q;
      end
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!r_err && rsel_q == SEL_W'(i)) begin
        if (r_state_q == R_ADDR) begin
          s_ar_valid_o[i]                 = m_ar_valid_i;
          s_ar_addr_o[i*ADDR_W +: ADDR_W] = m_ar_addr_i;
          s_ar_id_o[i*ID_W +: ID_W]       = m_ar_id_i;
          s_ar_len_o[i*8 +: 8]            = m_ar_len_i;
          s_ar_size_o[i*3 +: 3]           = m_ar_size_i;
          s_ar_burst_o[i*2 +: 2]          = m_ar_burst_i;
          m_ar_ready_o                    = s_ar_ready_i[i];
        end
        if (r_state_q == R_DATA) begin
          s_r_ready_o[i] = m_r_ready_i;
          m_r_valid_o    = s_r_valid_i[i];
          m_r_resp_o     = s_r_resp_i[i*2 +: 2];
          m_r_data_o     = s_r_data_i[i*DATA_W +: DATA_W];
          m_r_last_o     = s_r_last_i[i];
          m_r_id_o       = s_r_id_i[i*ID_W +: ID_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_axi_demux_n.sv
// Directed bench for the AXI demux.
// Slave 0 is 0x0200_xxxx, slave 1 is 0x8xxx_xxxx, and every other address goes to the error slave.
module tb_ysyx_23060077_axi_demux_n;
  localparam int NS = 2;

  logic aclk = 1'b0;
  logic areset_n;
  logic        m_aw_valid_i, m_aw_ready_o, m_w_valid_i, m_w_last_i, m_w_ready_o;
  logic [31:0] m_aw_addr_i, m_w_data_i, m_ar_addr_i, m_r_data_o;
  logic [3:0]  m_aw_id_i, m_w_strb_i, m_b_id_o, m_ar_id_i, m_r_id_o;
  logic [7:0]  m_aw_len_i, m_ar_len_i;
  logic [2:0]  m_aw_size_i, m_ar_size_i;
  logic [1:0]  m_aw_burst_i, m_ar_burst_i, m_b_resp_o, m_r_resp_o;
  logic        m_b_ready_i, m_b_valid_o, m_ar_valid_i, m_ar_ready_o;
  logic        m_r_ready_i, m_r_valid_o, m_r_last_o;
  logic [NS-1:0]   s_aw_valid_o, s_aw_ready_i, s_w_valid_o, s_w_last_o, s_w_ready_i;
  logic [NS-1:0]   s_b_ready_o, s_b_valid_i, s_ar_valid_o, s_ar_ready_i;
  logic [NS-1:0]   s_r_ready_o, s_r_valid_i, s_r_last_i;
  logic [NS*32-1:0] s_aw_addr_o, s_w_data_o, s_ar_addr_o, s_r_data_i;
  logic [NS*4-1:0]  s_aw_id_o, s_w_strb_o, s_b_id_i, s_ar_id_o, s_r_id_i;
  logic [NS*8-1:0]  s_aw_len_o, s_ar_len_o;
  logic [NS*3-1:0]  s_aw_size_o, s_ar_size_o;
  logic [NS*2-1:0]  s_aw_burst_o, s_ar_burst_o, s_b_resp_i, s_r_resp_i;
  logic [1:0]       dbg_w_state_o, dbg_r_state_o;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  ysyx_23060077_axi_demux_n #(
    .NUM_SLV(2), .ADDR_W(32), .DATA_W(32), .ID_W(4),
    .SLV_BASE({32'h8000_0000, 32'h0200_0000}),
    .SLV_MASK({32'hF000_0000, 32'hFFFF_0000})
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .m_aw_valid_i(m_aw_valid_i), .m_aw_addr_i(m_aw_addr_i), .m_aw_id_i(m_aw_id_i),
    .m_aw_len_i(m_aw_len_i), .m_aw_size_i(m_aw_size_i), .m_aw_burst_i(m_aw_burst_i),
    .m_aw_ready_o(m_aw_ready_o),
    .m_w_valid_i(m_w_valid_i), .m_w_data_i(m_w_data_i), .m_w_strb_i(m_w_strb_i),
    .m_w_last_i(m_w_last_i), .m_w_ready_o(m_w_ready_o),
    .m_b_ready_i(m_b_ready_i), .m_b_valid_o(m_b_valid_o), .m_b_resp_o(m_b_resp_o), .m_b_id_o(m_b_id_o),
    .m_ar_valid_i(m_ar_valid_i), .m_ar_addr_i(m_ar_addr_i), .m_ar_id_i(m_ar_id_i),
    .m_ar_len_i(m_ar_len_i), .m_ar_size_i(m_ar_size_i), .m_ar_burst_i(m_ar_burst_i),
    .m_ar_ready_o(m_ar_ready_o),
    .m_r_ready_i(m_r_ready_i), .m_r_valid_o(m_r_valid_o), .m_r_resp_o(m_r_resp_o),
    .m_r_data_o(m_r_data_o), .m_r_last_o(m_r_last_o), .m_r_id_o(m_r_id_o),
    .s_aw_valid_o(s_aw_valid_o), .s_aw_addr_o(s_aw_addr_o), .s_aw_id_o(s_aw_id_o),
    .s_aw_len_o(s_aw_len_o), .s_aw_size_o(s_aw_size_o), .s_aw_burst_o(s_aw_burst_o),
    .s_aw_ready_i(s_aw_ready_i),
    .s_w_valid_o(s_w_valid_o), .s_w_data_o(s_w_data_o), .s_w_strb_o(s_w_strb_o),
    .s_w_last_o(s_w_last_o), .s_w_ready_i(s_w_ready_i),
    .s_b_ready_o(s_b_ready_o), .s_b_valid_i(s_b_valid_i), .s_b_resp_i(s_b_resp_i), .s_b_id_i(s_b_id_i),
    .s_ar_valid_o(s_ar_valid_o), .s_ar_addr_o(s_ar_addr_o), .s_ar_id_o(s_ar_id_o),
    .s_ar_len_o(s_ar_len_o), .s_ar_size_o(s_ar_size_o), .s_ar_burst_o(s_ar_burst_o),
    .s_ar_ready_i(s_ar_ready_i),
    .s_r_ready_o(s_r_ready_o), .s_r_valid_i(s_r_valid_i), .s_r_resp_i(s_r_resp_i),
    .s_r_data_i(s_r_data_i), .s_r_last_i(s_r_last_i), .s_r_id_i(s_r_id_i),
    .dbg_w_state_o(dbg_w_state_o), .dbg_r_state_o(dbg_r_state_o)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drivers: inputs change just after the falling edge, outputs are sampled 1 time unit later
  task automatic clr_in();
    m_aw_valid_i = 0; m_aw_addr_i = 0; m_aw_id_i = 0; m_aw_len_i = 0; m_aw_size_i = 3'd2; m_aw_burst_i = 2'd1;
    m_w_valid_i = 0; m_w_data_i = 0; m_w_strb_i = 0; m_w_last_i = 0; m_b_ready_i = 0;
    m_ar_valid_i = 0; m_ar_addr_i = 0; m_ar_id_i = 0; m_ar_len_i = 0; m_ar_size_i = 3'd2; m_ar_burst_i = 2'd1;
    m_r_ready_i = 0;
    s_aw_ready_i = 0; s_w_ready_i = 0; s_b_valid_i = 0; s_b_resp_i = 0; s_b_id_i = 0;
    s_ar_ready_i = 0; s_r_valid_i = 0; s_r_resp_i = 0; s_r_data_i = 0; s_r_last_i = 0; s_r_id_i = 0;
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  initial begin
    clr_in();
    areset_n = 0;
    repeat (2) step();
    #1;
    check_val("rst_s_aw_valid", s_aw_valid_o, 0);
    check_val("rst_m_aw_ready", m_aw_ready_o, 0);
    check_val("rst_m_r_valid", m_r_valid_o, 0);
    check_val("rst_states", {dbg_w_state_o, dbg_r_state_o}, 0);
    areset_n = 1;

    // write to slave 0 (0x0200_4000), id 3
    step(); m_aw_valid_i = 1; m_aw_addr_i = 32'h0200_4000; m_aw_id_i = 4'd3; #1;
    check_val("w0_idle_ready", m_aw_ready_o, 0);
    check_val("w0_idle_saw", s_aw_valid_o, 0);
    step(); #1;
    check_val("w0_saw_valid", s_aw_valid_o, 2'b01);
    check_val("w0_saw_addr", s_aw_addr_o[31:0], 32'h0200_4000);
    check_val("w0_saw_id", s_aw_id_o[3:0], 4'd3);
    s_aw_ready_i = 2'b01; #1;
    check_val("w0_aw_ready", m_aw_ready_o, 1);
    step(); clr_in(); m_w_valid_i = 1; m_w_data_i = 32'hDEAD_BEEF; m_w_strb_i = 4'hF; m_w_last_i = 1;
    s_w_ready_i = 2'b01; #1;
    check_val("w0_sw_valid", s_w_valid_o, 2'b01);
    check_val("w0_sw_data", s_w_data_o, {32'h0, 32'hDEAD_BEEF});
    check_val("w0_w_ready", m_w_ready_o, 1);
    step(); clr_in(); s_b_valid_i = 2'b11; s_b_resp_i = 4'b10_00; s_b_id_i = 8'h73; m_b_ready_i = 1; #1;
    check_val("w0_b", {m_b_valid_o, m_b_resp_o, m_b_id_o}, {1'b1, 2'b00, 4'd3});
    check_val("w0_s_b_ready", s_b_ready_o, 2'b01);
    step(); clr_in(); s_b_valid_i = 2'b11; #1;
    check_val("w0_idle_b", m_b_valid_o, 0);

    // read from slave 1 (0x8000_0010), len 3, id 2: four beats with last on the fourth
    step(); clr_in(); m_ar_valid_i = 1; m_ar_addr_i = 32'h8000_0010; m_ar_id_i = 4'd2; m_ar_len_i = 8'd3;
    step(); #1;
    check_val("r1_sar_valid", s_ar_valid_o, 2'b10);
    check_val("r1_sar_len", s_ar_len_o[15:8], 8'd3);
    s_ar_ready_i = 2'b10; #1;
    check_val("r1_ar_ready", m_ar_ready_o, 1);
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h100 + k);
    for (int k = 0; k < 4; k++) begin
      step(); clr_in();
      s_r_valid_i = 2'b11; s_r_data_i = {32'h100 + k, 32'hBAD0_0000};
      s_r_last_i = {(k == 3), 1'b1}; s_r_id_i = 8'h2F; s_r_resp_i = 4'b00_10; m_r_ready_i = 1; #1;
      exp_v = exp_q.pop_front();
      check_val("r1_data", m_r_data_o, exp_v);
      check_val("r1_meta", {m_r_valid_o, m_r_last_o, m_r_id_o, m_r_resp_o}, {1'b1, (k == 3), 4'd2, 2'b00});
      check_val("r1_s_r_ready", s_r_ready_o, 2'b10);
    end
    step(); clr_in(); s_r_valid_i = 2'b11; #1;
    check_val("r1_idle_r", m_r_valid_o, 0);

    // unmapped read 0x1000_0000, len 1, id 5: two DECERR beats of zero data
    step(); clr_in(); m_ar_valid_i = 1; m_ar_addr_i = 32'h1000_0000; m_ar_id_i = 4'd5; m_ar_len_i = 8'd1;
    step(); #1;
    check_val("re_ar_ready", m_ar_ready_o, 1);
    check_val("re_sar_valid", s_ar_valid_o, 0);
    for (int k = 0; k < 2; k++) begin
      step(); clr_in(); m_r_ready_i = 1; #1;
      check_val("re_beat", {m_r_valid_o, m_r_data_o, m_r_resp_o, m_r_id_o, m_r_last_o},
                {1'b1, 32'h0, 2'b11, 4'd5, (k == 1)});
    end
    step(); clr_in(); #1;
    check_val("re_idle", m_r_valid_o, 0);

    // unmapped write, len 0, id 9
    step(); m_aw_valid_i = 1; m_aw_addr_i = 32'h3000_0000; m_aw_id_i = 4'd9;
    step(); #1;
    check_val("we_aw_ready", {m_aw_ready_o, s_aw_valid_o}, {1'b1, 2'b00});
    step(); clr_in(); m_w_valid_i = 1; m_w_last_i = 1; #1;
    check_val("we_w_ready", {m_w_ready_o, s_w_valid_o}, {1'b1, 2'b00});
    step(); clr_in(); m_b_ready_i = 1; #1;
    check_val("we_b", {m_b_valid_o, m_b_resp_o, m_b_id_o}, {1'b1, 2'b11, 4'd9});
    step(); clr_in(); #1;
    check_val("we_idle_b", m_b_valid_o, 0);

    // concurrent write to slave 0 and read from slave 1; the AW address changes after the latch
    step(); m_aw_valid_i = 1; m_aw_addr_i = 32'h0200_0100; m_aw_id_i = 4'd1;
    m_ar_valid_i = 1; m_ar_addr_i = 32'h8000_0000; m_ar_id_i = 4'd4; m_ar_len_i = 8'd0;
    step(); m_aw_addr_i = 32'h8000_0040; s_aw_ready_i = 2'b11; s_ar_ready_i = 2'b11; #1;
    check_val("cc_route", {s_aw_valid_o, s_ar_valid_o}, {2'b01, 2'b10});
    check_val("cc_readies", {m_aw_ready_o, m_ar_ready_o}, 2'b11);
    step(); clr_in(); m_w_valid_i = 1; m_w_last_i = 1; s_w_ready_i = 2'b01;
    s_r_valid_i = 2'b10; s_r_last_i = 2'b10; s_r_data_i = {32'hCAFE_0001, 32'h0}; s_r_id_i = 8'h40; m_r_ready_i = 1; #1;
    check_val("cc_w", {m_w_ready_o, s_w_valid_o}, {1'b1, 2'b01});
    check_val("cc_r", {m_r_valid_o, m_r_last_o, m_r_data_o, m_r_id_o}, {1'b1, 1'b1, 32'hCAFE_0001, 4'd4});
    step(); clr_in(); s_b_valid_i = 2'b01; s_b_id_i = 8'h01; m_b_ready_i = 1; s_r_valid_i = 2'b11; #1;
    check_val("cc_b", {m_b_valid_o, m_b_id_o, m_b_resp_o}, {1'b1, 4'd1, 2'b00});
    check_val("cc_r_idle", m_r_valid_o, 0);

    // reset asserted during beat 2 of a slave 1 read
    step(); clr_in(); m_ar_valid_i = 1; m_ar_addr_i = 32'h8000_0000; m_ar_id_i = 4'd6; m_ar_len_i = 8'd3;
    step(); s_ar_ready_i = 2'b10;
    step(); clr_in(); s_r_valid_i = 2'b10; s_r_id_i = 8'h60; m_r_ready_i = 1;
    step(); #1;
    check_val("rs_beat2_valid", m_r_valid_o, 1);
    areset_n = 0; #1;
    check_val("rs_valids", {m_r_valid_o, s_r_ready_o, s_ar_valid_o, m_b_valid_o}, 0);
    check_val("rs_state", dbg_r_state_o, 0);
    step(); clr_in(); areset_n = 1;
    step(); m_ar_valid_i = 1; m_ar_addr_i = 32'h4000_0000; m_ar_id_i = 4'd7; m_ar_len_i = 8'd0;
    step(); #1;
    check_val("rs_fresh_ar", m_ar_ready_o, 1);
    step(); clr_in(); m_r_ready_i = 1; #1;
    check_val("rs_fresh_r", {m_r_valid_o, m_r_last_o, m_r_id_o, m_r_resp_o}, {1'b1, 1'b1, 4'd7, 2'b11});
    step(); clr_in(); #1;
    check_val("rs_fresh_idle", m_r_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
